// File: rtl/truth_table_extractor.sv
// Sweeps every input combination into a combinational gate and assembles its truth-table code.
// Optional compare against an expected code is enabled by defining EXPECT_CHECK_EN.
module truth_table_extractor #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic [N_IN-1:0]        in_vec,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_code,
  output logic                   code_valid
`ifdef EXPECT_CHECK_EN
  ,
  input  logic [(1<<N_IN)-1:0]   expected_code,
  output logic                   match
`endif
);

  localparam int NV = 1 << N_IN;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [N_IN:0] LAST_VEC    = (N_IN+1)'(NV - 1);
  localparam logic [CW-1:0] LAST_SETTLE = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [N_IN:0]     r_vec;
  logic [CW-1:0]     r_settle;
  logic [NV-1:0]     r_table;
  logic              r_busy;
  logic              r_done;
  logic              r_code_valid;
  logic              w_abort;
  logic              w_accept;
  logic              w_sample;
  logic              w_last_vec;
`ifdef EXPECT_CHECK_EN
  logic              r_match;
`endif

  // Qualified controls and next-state selection; abort outranks everything outside IDLE
  always_comb begin
    w_abort    = abort && (r_state != S_IDLE);
    w_accept   = start && !abort && (r_state == S_IDLE);
    w_sample   = (r_state == S_SETTLE) && (r_settle == LAST_SETTLE);
    w_last_vec = (r_vec == LAST_VEC);
    w_next     = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_next = S_SETTLE;
          end else begin
            w_next = S_IDLE;
          end
        end
        S_SETTLE: begin
          if (w_sample && w_last_vec) begin
            w_next = S_DONE;
          end else begin
            w_next = S_SETTLE;
          end
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Vector/settle counters, table capture and the registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec        <= '0;
      r_settle     <= '0;
      r_table      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_code_valid <= 1'b0;
`ifdef EXPECT_CHECK_EN
      r_match      <= 1'b0;
`endif
    end else begin
      r_busy <= (w_next == S_SETTLE);
      r_done <= 1'b0;
      if (w_abort) begin
        r_vec        <= '0;
        r_settle     <= '0;
        r_code_valid <= 1'b0;
`ifdef EXPECT_CHECK_EN
        r_match      <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_vec        <= '0;
              r_settle     <= '0;
              r_table      <= '0;
              r_code_valid <= 1'b0;
`ifdef EXPECT_CHECK_EN
              r_match      <= 1'b0;
`endif
            end
          end
          S_SETTLE: begin
            if (w_sample) begin
              r_table[r_vec[N_IN-1:0]] <= dut_out;
              r_settle                 <= '0;
              if (!w_last_vec) begin
                r_vec <= r_vec + (N_IN+1)'(1);
              end
            end else begin
              r_settle <= r_settle + CW'(1);
            end
          end
          S_DONE: begin
            r_done       <= 1'b1;
            r_code_valid <= 1'b1;
            r_vec        <= '0;
`ifdef EXPECT_CHECK_EN
            r_match      <= (r_table == expected_code);
`endif
          end
          default: begin
            r_vec    <= '0;
            r_settle <= '0;
          end
        endcase
      end
    end
  end

  assign in_vec     = r_vec[N_IN-1:0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign table_code = r_table;
  assign code_valid = r_code_valid;
`ifdef EXPECT_CHECK_EN
  assign match      = r_match;
`endif

endmodule

// File: tb/tb_truth_table_extractor.sv
// Directed + randomized bench for truth_table_extractor (N_IN=3, SETTLE_CYCLES=4).
// A behavioural gate model drives dut_out; expected codes come from evaluating that model over all inputs.
module tb_truth_table_extractor;
  localparam int N_IN = 3;
  localparam int NV   = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       code_valid;
  logic [2:0] in_vec;
  logic [7:0] table_code;
`ifdef EXPECT_CHECK_EN
  logic [7:0] expected_code;
  logic       match;
`endif

  int         total = 0;
  int         bad   = 0;
  int         mode  = 0;
  logic [7:0] rtbl  = 8'h00;

  always #5 clk = ~clk;

  truth_table_extractor #(.N_IN(N_IN), .SETTLE_CYCLES(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .in_vec     (in_vec),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
    .table_code (table_code),
    .code_valid (code_valid)
`ifdef EXPECT_CHECK_EN
    ,
    .expected_code (expected_code),
    .match         (match)
`endif
  );

  // Gate under test: 0 equality, 1 const-1, 2 const-0, 3 AND3, otherwise random lookup table
  function automatic logic gate(input int m, input int v, input logic [7:0] tbl);
    int a, b, c;
    a = (v >> 2) & 1;
    b = (v >> 1) & 1;
    c = v & 1;
    case (m)
      0:       return (a == b) && (b == c);
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return (a + b + c) == 3;
      default: return tbl[v];
    endcase
  endfunction

  function automatic logic [7:0] model_code();
    logic [7:0] c;
    c = 8'h00;
    for (int v = 0; v < NV; v++) c[v] = gate(mode, v, rtbl);
    return c;
  endfunction

  always_comb dut_out = gate(mode, int'(in_vec), rtbl);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full sweep from a start pulse; optionally re-pulses start at edges 5 and 20
  task automatic sweep(input string tag, input bit extra_starts);
    logic [7:0] exp;
    int dcnt;
    int dedge;
    int ev;
    exp   = model_code();
    dcnt  = 0;
    dedge = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_e0"}, 64'(busy), 64'd1);
    chk({tag, "_cv_cleared"}, 64'(code_valid), 64'd0);
`ifdef EXPECT_CHECK_EN
    chk({tag, "_match_cleared"}, 64'(match), 64'd0);
`endif
    for (int e = 1; e <= 40; e++) begin
      start = extra_starts && (e == 5 || e == 20);
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        dcnt++;
        dedge = e;
      end
      if (e == 3 || e == 4 || e == 16 || e == 32) begin
        ev = (e / 4 > 7) ? 7 : e / 4;
        chk($sformatf("%s_invec_e%0d", tag, e), 64'(in_vec), 64'(ev));
      end
      if (e == 32) chk({tag, "_busy_e32"}, 64'(busy), 64'd0);
    end
    chk({tag, "_done_cnt"}, 64'(dcnt), 64'd1);
    chk({tag, "_done_edge"}, 64'(dedge), 64'd33);
    chk({tag, "_code"}, 64'(table_code), 64'(exp));
    chk({tag, "_code_valid"}, 64'(code_valid), 64'd1);
    chk({tag, "_invec_end"}, 64'(in_vec), 64'd0);
  endtask

  initial begin
    int dcnt;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
`ifdef EXPECT_CHECK_EN
    expected_code = 8'h81;
`endif
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_invec", 64'(in_vec), 64'd0);
    chk("rst_code", 64'(table_code), 64'd0);
    chk("rst_cv", 64'(code_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    mode = 0;
    sweep("eq", 1'b0);
    chk("eq_const81", 64'(table_code), 64'h81);
`ifdef EXPECT_CHECK_EN
    chk("eq_match", 64'(match), 64'd1);
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_cv", 64'(code_valid), 64'd1);
    chk("idle_abort_code", 64'(table_code), 64'h81);

    mode = 1; sweep("ones", 1'b0);
    chk("ones_constFF", 64'(table_code), 64'hFF);
    mode = 2; sweep("zeros", 1'b0);
    chk("zeros_const00", 64'(table_code), 64'h00);
    mode = 3; sweep("and3", 1'b0);
    chk("and3_const80", 64'(table_code), 64'h80);
`ifdef EXPECT_CHECK_EN
    chk("and3_match", 64'(match), 64'd0);
`endif

    mode = 0;
    sweep("restart_ignored", 1'b1);

    // Abort mid-sweep at edge 12
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 11; e++) tick();
    chk("abort_pre_busy", 64'(busy), 64'd1);
    chk("abort_pre_invec", 64'(in_vec), 64'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_invec", 64'(in_vec), 64'd0);
    chk("abort_cv", 64'(code_valid), 64'd0);
    dcnt = 0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    chk("abort_idle_busy", 64'(busy), 64'd0);
    mode = 3;
    sweep("after_abort", 1'b0);

    // Start and abort together in IDLE: start is dropped
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    chk("start_abort_busy", 64'(busy), 64'd0);
    chk("start_abort_cv", 64'(code_valid), 64'd1);

    // Asynchronous reset between edges 16 and 17
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 16; e++) tick();
    chk("rst_mid_pre_invec", 64'(in_vec), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_invec", 64'(in_vec), 64'd0);
    chk("rst_mid_code", 64'(table_code), 64'd0);
    chk("rst_mid_cv", 64'(code_valid), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    mode = 0;
    sweep("after_rst", 1'b0);

    for (int k = 0; k < 4; k++) begin
      mode = 4;
      rtbl = 8'($urandom);
      sweep($sformatf("rand%0d", k), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
